// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer/count helpers for the parametrised FIFO
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    // Count must hold 0..depth inclusive, hence one bit more than the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer handshake and status bundle of the FIFO
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int CW         = cnt_w(DEF_FIFO_DEPTH)
);
    logic                  flush;
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - dual-port storage: synchronous write, asynchronous read address
module fifo_mem #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
    input  logic [FIFO_WIDTH-1:0]         wdata,
    input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
    output logic [FIFO_WIDTH-1:0]         rdata
);
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised synchronous FIFO; FIFO_FWFT_EN selects first-word-fall-through reads
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AFULL_LVL  = FIFO_DEPTH - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [FIFO_WIDTH-1:0] rdata;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A full FIFO refuses the write even when a read frees a slot on the same edge.
    assign wr_ok = !bus.flush && bus.wr_en && !full;
    assign rd_ok = !bus.flush && bus.rd_en && !empty;

    fifo_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= PW'(next_ptr(int'(wr_ptr), FIFO_DEPTH));
            end
            if (rd_ok) begin
                rd_ptr <= PW'(next_ptr(int'(rd_ptr), FIFO_DEPTH));
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
            wr_ack    <= wr_ok;
            overflow  <= bus.wr_en && full;
            underflow <= bus.rd_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out = empty ? '0 : rdata;
`else
    logic [FIFO_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= rdata;
        end
    end

    assign bus.data_out = dout_q;
`endif

    assign bus.count       = count;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count >= CW'(AFULL_LVL)) && !full;
    assign bus.almostempty = (count <= CW'(AEMPTY_LVL)) && !empty;
    assign bus.wr_ack      = wr_ack;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed and random scoreboard bench for fifo_sync_param (DEPTH 8 and 5)
module tb_fifo_sync_param;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] q[$];
    logic [15:0] std_dout = 16'h0;

    fifo_sync_param_if #(.FIFO_WIDTH(16), .CW(4)) b8 ();
    fifo_sync_param_if #(.FIFO_WIDTH(16), .CW(4)) b5 ();

    fifo_sync_param #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (8),
        .AFULL_LVL  (6),
        .AEMPTY_LVL (2)
    ) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    fifo_sync_param #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (5)
    ) u5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input bit f, input bit w, input bit r, input logic [15:0] d);
        b8.flush = 1'b0; b8.wr_en = 1'b0; b8.rd_en = 1'b0; b8.data_in = 16'h0;
        b5.flush = 1'b0; b5.wr_en = 1'b0; b5.rd_en = 1'b0; b5.data_in = 16'h0;
        if (sel == 1) begin
            b5.flush = f; b5.wr_en = w; b5.rd_en = r; b5.data_in = d;
        end else begin
            b8.flush = f; b8.wr_en = w; b8.rd_en = r; b8.data_in = d;
        end
    endtask

    // Compares every output of the selected FIFO against the scoreboard model.
    task automatic chk_state(input int sel, input string tag, input bit e_ack, input bit e_ovf, input bit e_udf);
        int n;
        int depth;
        int afl;
        int ael;
        logic [15:0] ed;
        logic [15:0] od;
        logic [3:0]  oc;
        logic        of, oe, oaf, oae, oack, oovf, oudf;
        n     = q.size();
        depth = (sel == 1) ? 5 : 8;
        afl   = (sel == 1) ? 4 : 6;
        ael   = (sel == 1) ? 1 : 2;
`ifdef FIFO_FWFT_EN
        ed = (n != 0) ? q[0] : 16'h0;
`else
        ed = std_dout;
`endif
        if (sel == 1) begin
            od = b5.data_out; oc = b5.count; of = b5.full; oe = b5.empty;
            oaf = b5.almostfull; oae = b5.almostempty;
            oack = b5.wr_ack; oovf = b5.overflow; oudf = b5.underflow;
        end else begin
            od = b8.data_out; oc = b8.count; of = b8.full; oe = b8.empty;
            oaf = b8.almostfull; oae = b8.almostempty;
            oack = b8.wr_ack; oovf = b8.overflow; oudf = b8.underflow;
        end
        chk({tag, ".count"},       32'(oc),   32'(n));
        chk({tag, ".full"},        32'(of),   32'(n == depth));
        chk({tag, ".empty"},       32'(oe),   32'(n == 0));
        chk({tag, ".almostfull"},  32'(oaf),  32'((n >= afl) && (n != depth)));
        chk({tag, ".almostempty"}, 32'(oae),  32'((n <= ael) && (n != 0)));
        chk({tag, ".wr_ack"},      32'(oack), 32'(e_ack));
        chk({tag, ".overflow"},    32'(oovf), 32'(e_ovf));
        chk({tag, ".underflow"},   32'(oudf), 32'(e_udf));
        chk({tag, ".data_out"},    32'(od),   32'(ed));
    endtask

    // One clock of stimulus: drive, let the edge pass, update the model, check.
    task automatic op(input int sel, input string tag, input bit f, input bit w, input bit r, input logic [15:0] d);
        int  depth;
        bit  full_pre;
        bit  empty_pre;
        bit  wacc;
        bit  racc;
        depth     = (sel == 1) ? 5 : 8;
        full_pre  = (q.size() == depth);
        empty_pre = (q.size() == 0);
        drive(sel, f, w, r, d);
        @(posedge clk);
        #1;
        wacc = !f && w && !full_pre;
        racc = !f && r && !empty_pre;
        if (f) begin
            q.delete();
        end else begin
            if (racc) std_dout = q.pop_front();
            if (wacc) q.push_back(d);
        end
        chk_state(sel, tag, wacc, !f && w && full_pre, !f && r && empty_pre);
    endtask

    initial begin
        bit rw;
        bit rr;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        chk_state(0, "reset8", 1'b0, 1'b0, 1'b0);
        chk_state(1, "reset5", 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 8; i++) op(0, $sformatf("fill%0d", i), 1'b0, 1'b1, 1'b0, 16'(i));
        op(0, "wr_full", 1'b0, 1'b1, 1'b0, 16'h0099);
        op(0, "idle_after_ovf", 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 8; i++) op(0, $sformatf("read%0d", i), 1'b0, 1'b0, 1'b1, 16'h0);
        op(0, "rd_empty", 1'b0, 1'b0, 1'b1, 16'h0);
        op(0, "idle_after_udf", 1'b0, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 4; i++) op(0, "fill_to4", 1'b0, 1'b1, 1'b0, 16'(16'h0010 + i));
        op(0, "rw_at4", 1'b0, 1'b1, 1'b1, 16'h0014);
        for (int i = 0; i < 4; i++) op(0, "drain_order", 1'b0, 1'b0, 1'b1, 16'h0);
        op(0, "rw_empty", 1'b0, 1'b1, 1'b1, 16'h0020);
        for (int i = 1; i <= 7; i++) op(0, "fill_to8", 1'b0, 1'b1, 1'b0, 16'(16'h0020 + i));
        op(0, "rw_full", 1'b0, 1'b1, 1'b1, 16'h0030);
        op(0, "rd_to6", 1'b0, 1'b0, 1'b1, 16'h0);
        op(0, "rd_to5", 1'b0, 1'b0, 1'b1, 16'h0);
        op(0, "flush_wr", 1'b1, 1'b1, 1'b0, 16'h0040);
        op(0, "after_flush", 1'b0, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 3; i++) op(0, "burst", 1'b0, 1'b1, 1'b0, 16'(16'h0050 + i));
        op(0, "burst_rd", 1'b0, 1'b0, 1'b1, 16'h0);
        drive(0, 1'b0, 1'b1, 1'b0, 16'h00AA);
        #3 rst_n = 1'b0;
        #1;
        q.delete();
        std_dout = 16'h0;
        chk_state(0, "midrst", 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            rw = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            op(1, $sformatf("rand%0d", i), 1'b0, rw, rr, 16'($urandom));
            chk($sformatf("rand%0d.max", i), 32'(b5.count <= 4'd5), 32'd1);
        end
        for (int i = 0; i < 6; i++) op(1, "rand_drain", 1'b0, 1'b0, 1'b1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
